// File: rtl/alu_op_pkg.sv
// Shared encodings for the ALU operation sequencer: operation codes, ALUOp and
// funct7 selectors, and the issue FSM state type.
package alu_op_pkg;

  localparam logic [4:0] OP_AND    = 5'd0;
  localparam logic [4:0] OP_OR     = 5'd1;
  localparam logic [4:0] OP_XOR    = 5'd2;
  localparam logic [4:0] OP_ADD    = 5'd3;
  localparam logic [4:0] OP_SUB    = 5'd4;
  localparam logic [4:0] OP_SRL    = 5'd5;
  localparam logic [4:0] OP_SRA    = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_EQ     = 5'd9;
  localparam logic [4:0] OP_NE     = 5'd10;
  localparam logic [4:0] OP_SLT    = 5'd11;
  localparam logic [4:0] OP_GE     = 5'd12;
  localparam logic [4:0] OP_LUI    = 5'd13;
  localparam logic [4:0] OP_SLTU   = 5'd14;
  localparam logic [4:0] OP_GEU    = 5'd15;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;
  localparam logic [1:0] ALUOP_JL  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of ALUOp/funct3/funct7 into the wide operation code.
// Illegal encodings collapse to ADD with the illegal flag raised.
module alu_op_decode
  import alu_op_pkg::*;
#(
  parameter int OP_W = 5,
  parameter int EN_M = 1
) (
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic            itype,
  output logic [OP_W-1:0] code,
  output logic            is_muldiv,
  output logic            illegal
);

  logic [4:0] raw;

  always_comb begin
    raw       = OP_ADD;
    is_muldiv = 1'b0;
    illegal   = 1'b0;
    case (alu_op)
      ALUOP_MEM: raw = OP_ADD;
      ALUOP_BR: begin
        case (funct3)
          3'b000:  raw = OP_EQ;
          3'b001:  raw = OP_NE;
          3'b100:  raw = OP_SLT;
          3'b101:  raw = OP_GE;
          3'b110:  raw = OP_SLTU;
          3'b111:  raw = OP_GEU;
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_RI: begin
        if (itype) begin
          // Only shifts look at funct7 for I-type arithmetic
          case (funct3)
            3'b000: raw = OP_ADD;
            3'b010: raw = OP_SLT;
            3'b011: raw = OP_SLTU;
            3'b100: raw = OP_XOR;
            3'b110: raw = OP_OR;
            3'b111: raw = OP_AND;
            3'b001: begin
              if (funct7 == F7_BASE) raw = OP_SLL;
              else                   illegal = 1'b1;
            end
            default: begin
              if (funct7 == F7_BASE)     raw = OP_SRL;
              else if (funct7 == F7_ALT) raw = OP_SRA;
              else                       illegal = 1'b1;
            end
          endcase
        end else if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  raw = OP_ADD;
            3'b001:  raw = OP_SLL;
            3'b010:  raw = OP_SLT;
            3'b011:  raw = OP_SLTU;
            3'b100:  raw = OP_XOR;
            3'b101:  raw = OP_SRL;
            3'b110:  raw = OP_OR;
            default: raw = OP_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  raw = OP_SUB;
            3'b101:  raw = OP_SRA;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == F7_MULDIV && EN_M != 0) begin
          raw       = {2'b10, funct3};
          is_muldiv = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: raw = OP_LUI;
    endcase
    if (illegal) begin
      raw       = OP_ADD;
      is_muldiv = 1'b0;
    end
  end

  assign code = OP_W'(raw);

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered, handshaked ALU operation issue stage: decodes the request and
// holds MUL/DIV operations for their programmed latency before presenting them.
module alu_op_sequencer
  import alu_op_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int EN_M    = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic            itype,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] operation,
  output logic            is_muldiv,
  output logic            illegal
);

  if ((EN_M != 0 && OP_W < 5) || (EN_M == 0 && OP_W < 4)) begin : g_bad_op_w
    $error("alu_op_sequencer: OP_W too narrow for the enabled operation set");
  end
  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("alu_op_sequencer: MUL_LAT must be in 1..15");
  end
  if (DIV_LAT < 1 || DIV_LAT > 63) begin : g_bad_div_lat
    $error("alu_op_sequencer: DIV_LAT must be in 1..63");
  end

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  logic [OP_W-1:0] dec_code;
  logic            dec_md;
  logic            dec_ill;

  alu_op_decode #(.OP_W(OP_W), .EN_M(EN_M)) u_decode (
    .alu_op    (alu_op),
    .funct7    (funct7),
    .funct3    (funct3),
    .itype     (itype),
    .code      (dec_code),
    .is_muldiv (dec_md),
    .illegal   (dec_ill)
  );

  state_t          state, state_n;
  logic [5:0]      cnt, cnt_n, lat_cnt;
  logic            accept, load;
  logic [OP_W-1:0] op_p1;
  logic            md_p1, ill_p1;

  assign in_ready = !flush && (state == IDLE || (state == HOLD && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    lat_cnt = '0;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: load = accept;
        WAIT: begin
          if (cnt == '0) state_n = HOLD;
          else           cnt_n   = cnt - 6'd1;
        end
        HOLD: begin
          if (out_ready) begin
            if (accept) load    = 1'b1;
            else        state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
      // Codes 20-23 (bit 2 set) are the divide/remainder group
      if (load) begin
        lat_cnt = dec_code[2] ? DIV_CNT : MUL_CNT;
        if (dec_md && lat_cnt != '0) begin
          state_n = WAIT;
          cnt_n   = lat_cnt;
        end else begin
          state_n = HOLD;
          cnt_n   = '0;
        end
      end
    end
  end

  // Stage p1: accepted operation, held until the consumer takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_p1  <= '0;
      md_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        op_p1  <= dec_code;
        md_p1  <= dec_md;
        ill_p1 <= dec_ill;
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign operation = op_p1;
  assign is_muldiv = md_p1;
  assign illegal   = ill_p1;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer (default M config plus an
// EN_M=0 instance for the illegal-M check).
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [4:0] op;
    logic       md;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_valid2 = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [6:0] funct7 = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       itype = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, is_muldiv, illegal;
  logic [4:0] operation;
  logic       in_ready2, out_valid2, is_muldiv2, illegal2;
  logic [3:0] operation2;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_op_sequencer dut (
    .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .itype(itype),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .operation(operation), .is_muldiv(is_muldiv), .illegal(illegal)
  );

  alu_op_sequencer #(.OP_W(4), .EN_M(0)) dut_nom (
    .clk(clk), .reset_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .itype(itype),
    .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
    .operation(operation2), .is_muldiv(is_muldiv2), .illegal(illegal2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request until accepted; returns 1 time unit after the accept edge.
  task automatic issue(input logic [1:0] a, input logic [6:0] f7, input logic [2:0] f3,
                       input logic it, input logic [4:0] eop, input logic emd,
                       input logic eill, input bit push);
    int k;
    alu_op = a; funct7 = f7; funct3 = f3; itype = it; in_valid = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 200) begin
      step();
      #1;
      k++;
    end
    chk("issue_ready", in_ready, 1);
    if (push) sb.push_back('{op: eop, md: emd, ill: eill});
    step();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      exp_t e;
      chk("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("xfer_op", operation, e.op);
        chk("xfer_md", is_muldiv, e.md);
        chk("xfer_ill", illegal, e.ill);
      end
    end
  end

  initial begin
    int c0, seen;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_operation", operation, 0);
    chk("rst_is_muldiv", is_muldiv, 0);
    chk("rst_illegal", illegal, 0);
    #10 rst_n = 1'b1;
    step();

    // SUB with latency 1
    issue(2'b10, 7'b0100000, 3'b000, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1);
    chk("sub_valid", out_valid, 1);
    chk("sub_op", operation, 4);
    chk("sub_illegal", illegal, 0);
    chk("sub_in_ready", in_ready, 1);
    step();

    // Back-to-back ADD, XOR, SLTU
    c0 = cyc;
    issue(2'b10, 7'b0000000, 3'b000, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
    chk("add_op", operation, 3);
    issue(2'b10, 7'b0000000, 3'b100, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1);
    chk("xor_op", operation, 2);
    issue(2'b10, 7'b0000000, 3'b011, 1'b0, 5'd14, 1'b0, 1'b0, 1'b1);
    chk("sltu_op", operation, 14);
    chk("stream_cycles", cyc - c0, 3);
    step();
    chk("stream_idle", out_valid, 0);

    // DIV with 32-cycle latency, then held with out_ready low
    out_ready = 1'b0;
    issue(2'b10, 7'b0000001, 3'b100, 1'b0, 5'd20, 1'b1, 1'b0, 1'b1);
    alu_op = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("div_wait_valid", out_valid, 0);
      chk("div_wait_ready", in_ready, 0);
      step();
    end
    chk("div_valid", out_valid, 1);
    chk("div_op", operation, 20);
    chk("div_md", is_muldiv, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("div_hold_valid", out_valid, 1);
      chk("div_hold_op", operation, 20);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("div_released", out_valid, 0);

    // MUL killed by flush, then BNE
    issue(2'b10, 7'b0000001, 3'b000, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready_after", in_ready, 1);
    step();
    chk("flush_no_late_valid", out_valid, 0);
    issue(2'b01, 7'b0000000, 3'b001, 1'b0, 5'd10, 1'b0, 1'b0, 1'b1);
    chk("bne_op", operation, 10);
    step();

    // MULHU at MUL_LAT=2
    issue(2'b10, 7'b0000001, 3'b011, 1'b0, 5'd19, 1'b1, 1'b0, 1'b1);
    chk("mulhu_lat0", out_valid, 0);
    step();
    chk("mulhu_lat1", out_valid, 0);
    step();
    chk("mulhu_valid", out_valid, 1);
    chk("mulhu_op", operation, 19);
    step();

    // I-type shifts and misc decodes
    issue(2'b10, 7'b0100000, 3'b101, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1);
    chk("srai_op", operation, 6);
    issue(2'b10, 7'b0000001, 3'b101, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1);
    chk("shift_bad_ill", illegal, 1);
    chk("shift_bad_op", operation, 3);
    issue(2'b10, 7'b0100000, 3'b001, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1);
    issue(2'b10, 7'b1111111, 3'b010, 1'b1, 5'd11, 1'b0, 1'b0, 1'b1);
    chk("slti_op", operation, 11);
    issue(2'b01, 7'b0000000, 3'b010, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
    issue(2'b11, 7'b0000000, 3'b000, 1'b0, 5'd13, 1'b0, 1'b0, 1'b1);
    chk("lui_op", operation, 13);
    issue(2'b00, 7'b0000000, 3'b000, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
    issue(2'b10, 7'b0000010, 3'b000, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
    chk("rtype_bad_f7_ill", illegal, 1);
    step();

    // EN_M=0 instance rejects R-type MUL
    alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b000; itype = 1'b0;
    in_valid2 = 1'b1;
    #1 chk("nom_in_ready", in_ready2, 1);
    step();
    in_valid2 = 1'b0;
    chk("nom_valid", out_valid2, 1);
    chk("nom_illegal", illegal2, 1);
    chk("nom_op", operation2, 3);
    chk("nom_md", is_muldiv2, 0);
    step();

    // Async reset in HOLD
    out_ready = 1'b0;
    issue(2'b01, 7'b0000000, 3'b011, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    chk("hold_pre_valid", out_valid, 1);
    chk("hold_pre_ill", illegal, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", out_valid, 0);
    chk("hold_rst_op", operation, 0);
    chk("hold_rst_ill", illegal, 0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Async reset in WAIT
    issue(2'b10, 7'b0000001, 3'b101, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0);
    step(); step(); step();
    chk("wait_pre_valid", out_valid, 0);
    chk("wait_pre_op", operation, 21);
    chk("wait_pre_md", is_muldiv, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("wait_rst_valid", out_valid, 0);
    chk("wait_rst_op", operation, 0);
    chk("wait_rst_md", is_muldiv, 0);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("wait_abort_no_output", seen, 0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
